// File: rtl/bist_misr_analyzer_if.sv
// Handshake bundle between the BIST controller/CUT side and the MISR response analyzer.
interface bist_misr_analyzer_if #(
   parameter int WIDTH = 3
);
   logic             start;
   logic             resp_valid;
   logic [WIDTH-1:0] resp_in;
   logic             lfsr_complete;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] signature;

   modport master (
      output start,
      output resp_valid,
      output resp_in,
      output lfsr_complete,
      input  busy,
      input  done,
      input  pass,
      input  signature
   );

   modport slave (
      input  start,
      input  resp_valid,
      input  resp_in,
      input  lfsr_complete,
      output busy,
      output done,
      output pass,
      output signature
   );
endinterface

// File: rtl/bist_misr_analyzer.sv
// MISR-based output response analyzer: folds CUT response words into a signature,
// then compares the signature against a golden value once compaction ends.
module bist_misr_analyzer #(
   parameter int               WIDTH        = 3,
   parameter logic [WIDTH-1:0] TAPS         = 3'b010,
   parameter logic [WIDTH-1:0] SEED         = '0,
   parameter int               NUM_PATTERNS = 7,
   parameter logic [WIDTH-1:0] GOLDEN       = 3'd4
) (
   input  logic                     clock,
   input  logic                     reset,
   bist_misr_analyzer_if.slave      bus
);

   localparam int            CW   = $clog2(NUM_PATTERNS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

   typedef enum logic [1:0] {
      IDLE,
      COMPACT,
      CHECK,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sig;
   logic [WIDTH-1:0] sig_next;
   logic [WIDTH-1:0] misr_fold;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             pass_q;
   logic             pass_next;

   // One MISR step: shift with feedback from the top stage, XOR in the response word.
   always_comb begin
      misr_fold    = '0;
      misr_fold[0] = sig[WIDTH-1] ^ bus.resp_in[0];
      for (int i = 1; i < WIDTH; i++) begin
         misr_fold[i] = sig[i-1] ^ (TAPS[i] & sig[WIDTH-1]) ^ bus.resp_in[i];
      end
   end

   always_comb begin
      state_next = state;
      sig_next   = sig;
      count_next = count;
      pass_next  = pass_q;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               sig_next   = SEED;
               count_next = '0;
               pass_next  = 1'b0;
               state_next = COMPACT;
            end
         end
         COMPACT: begin
            if (bus.resp_valid) begin
               sig_next   = misr_fold;
               count_next = count + CW'(1);
            end
            // Early end still folds a response presented in the same cycle.
            if ((bus.resp_valid && (count == LAST)) || bus.lfsr_complete) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            pass_next  = (sig == GOLDEN);
            state_next = DONE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         sig    <= SEED;
         count  <= '0;
         pass_q <= 1'b0;
      end else begin
         state  <= state_next;
         sig    <= sig_next;
         count  <= count_next;
         pass_q <= pass_next;
      end
   end

   assign bus.busy      = (state == COMPACT) || (state == CHECK);
   assign bus.done      = (state == DONE);
   assign bus.pass      = pass_q;
   assign bus.signature = sig;

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Directed, table-driven bench for bist_misr_analyzer with hand-computed signatures
// for x^3+x+1, seed 0, seven patterns, golden value 4.
module tb_bist_misr_analyzer;

   localparam int WIDTH = 3;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   bist_misr_analyzer_if #(.WIDTH(WIDTH)) bus ();

   bist_misr_analyzer #(
      .WIDTH        (WIDTH),
      .TAPS         (3'b010),
      .SEED         (3'd0),
      .NUM_PATTERNS (7),
      .GOLDEN       (3'd4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      logic       rst;
      logic       st;
      logic       rv;
      logic [2:0] din;
      logic       cmpl;
      logic       e_busy;
      logic       e_done;
      logic       e_pass;
      logic [2:0] e_sig;
   } vec_t;

   vec_t vecs[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   // Signature after each of the words 1..7 on the fault-free stream
   logic [2:0] gold_sig [1:7] = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd1, 3'd4, 3'd4};

   function automatic vec_t mkVec(string tag, logic rst, logic st, logic rv, logic [2:0] din,
                                  logic cmpl, logic eb, logic ed, logic ep, logic [2:0] es);
      vec_t v;
      v.tag    = tag;
      v.rst    = rst;
      v.st     = st;
      v.rv     = rv;
      v.din    = din;
      v.cmpl   = cmpl;
      v.e_busy = eb;
      v.e_done = ed;
      v.e_pass = ep;
      v.e_sig  = es;
      return v;
   endfunction

   function automatic void addVec(string tag, logic rst, logic st, logic rv, logic [2:0] din,
                                  logic cmpl, logic eb, logic ed, logic ep, logic [2:0] es);
      vecs.push_back(mkVec(tag, rst, st, rv, din, cmpl, eb, ed, ep, es));
   endfunction

   task automatic applyStimulus(input vec_t v);
      reset             = v.rst;
      bus.start         = v.st;
      bus.resp_valid    = v.rv;
      bus.resp_in       = v.din;
      bus.lfsr_complete = v.cmpl;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input vec_t v);
      tests_run++;
      if (bus.busy !== v.e_busy || bus.done !== v.e_done ||
          bus.pass !== v.e_pass || bus.signature !== v.e_sig) begin
         tests_failed++;
         $display("[TB] FAIL %s: got busy=%b done=%b pass=%b sig=%0d, expected busy=%b done=%b pass=%b sig=%0d",
                  v.tag, bus.busy, bus.done, bus.pass, bus.signature,
                  v.e_busy, v.e_done, v.e_pass, v.e_sig);
      end
   endtask

   task automatic runStep(input vec_t v);
      applyStimulus(v);
      checkOutput(v);
   endtask

   initial begin
      reset             = 1'b1;
      bus.start         = 1'b0;
      bus.resp_valid    = 1'b0;
      bus.resp_in       = '0;
      bus.lfsr_complete = 1'b0;

      // tag, rst, start, valid, din, complete | busy, done, pass, sig
      addVec("reset0",      1, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);
      addVec("reset1",      1, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);
      addVec("idle_valid",  0, 0, 1, 3'd5, 0, 0, 0, 0, 3'd0);
      addVec("idle_cmpl",   0, 0, 0, 3'd0, 1, 0, 0, 0, 3'd0);

      addVec("gold_start",  0, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0);
      for (int k = 1; k <= 7; k++)
         addVec($sformatf("gold_w%0d", k), 0, 0, 1, 3'(k), 0, 1, 0, 0, gold_sig[k]);
      addVec("gold_check",  0, 0, 0, 3'd0, 0, 0, 1, 1, 3'd4);
      addVec("done_valid",  0, 0, 1, 3'd3, 0, 0, 1, 1, 3'd4);
      addVec("done_cmpl",   0, 0, 0, 3'd0, 1, 0, 1, 1, 3'd4);

      // Third word corrupted to 7; start during compaction must be ignored
      addVec("fault_start", 0, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0);
      addVec("fault_w1",    0, 0, 1, 3'd1, 0, 1, 0, 0, 3'd1);
      addVec("fault_w2",    0, 0, 1, 3'd2, 0, 1, 0, 0, 3'd0);
      addVec("fault_w3",    0, 0, 1, 3'd7, 0, 1, 0, 0, 3'd7);
      addVec("fault_w4st",  0, 1, 1, 3'd4, 0, 1, 0, 0, 3'd1);
      addVec("fault_w5",    0, 0, 1, 3'd5, 0, 1, 0, 0, 3'd7);
      addVec("fault_w6",    0, 0, 1, 3'd6, 0, 1, 0, 0, 3'd3);
      addVec("fault_w7",    0, 0, 1, 3'd7, 0, 1, 0, 0, 3'd1);
      addVec("fault_check", 0, 0, 0, 3'd0, 0, 0, 1, 0, 3'd1);

      addVec("gap_start",   0, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0);
      for (int k = 1; k <= 7; k++) begin
         addVec($sformatf("gap_w%0d", k), 0, 0, 1, 3'(k), 0, 1, 0, 0, gold_sig[k]);
         if (k < 7)
            addVec($sformatf("gap_idle%0d", k), 0, 0, 0, 3'd7, 0, 1, 0, 0, gold_sig[k]);
      end
      addVec("gap_check",   0, 0, 0, 3'd0, 0, 0, 1, 1, 3'd4);

      addVec("early_start", 0, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0);
      addVec("early_w1",    0, 0, 1, 3'd1, 0, 1, 0, 0, 3'd1);
      addVec("early_w2",    0, 0, 1, 3'd2, 0, 1, 0, 0, 3'd0);
      addVec("early_w3c",   0, 0, 1, 3'd3, 1, 1, 0, 0, 3'd3);
      addVec("early_check", 0, 0, 1, 3'd5, 0, 0, 1, 0, 3'd3);
      addVec("early_hold",  0, 0, 1, 3'd6, 0, 0, 1, 0, 3'd3);

      addVec("cmpl_start",  0, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0);
      addVec("cmpl_w1",     0, 0, 1, 3'd1, 0, 1, 0, 0, 3'd1);
      addVec("cmpl_only",   0, 0, 0, 3'd6, 1, 1, 0, 0, 3'd1);
      addVec("cmpl_check",  0, 0, 0, 3'd0, 0, 0, 1, 0, 3'd1);

      foreach (vecs[i]) runStep(vecs[i]);

      // Last word and lfsr_complete together: one fold, one CHECK; start in CHECK ignored
      runStep(mkVec("both_start", 0, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0));
      for (int k = 1; k <= 6; k++)
         runStep(mkVec($sformatf("both_w%0d", k), 0, 0, 1, 3'(k), 0, 1, 0, 0, gold_sig[k]));
      runStep(mkVec("both_w7c",    0, 0, 1, 3'd7, 1, 1, 0, 0, 3'd4));
      runStep(mkVec("check_start", 0, 1, 0, 3'd0, 0, 0, 1, 1, 3'd4));
      runStep(mkVec("both_hold",   0, 0, 0, 3'd0, 0, 0, 1, 1, 3'd4));

      // Reset in the middle of compaction discards progress and never produces done
      runStep(mkVec("mid_start",   0, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0));
      runStep(mkVec("mid_w1",      0, 0, 1, 3'd1, 0, 1, 0, 0, 3'd1));
      runStep(mkVec("mid_w4",      0, 0, 1, 3'd4, 0, 1, 0, 0, 3'd6));
      runStep(mkVec("mid_reset0",  1, 0, 1, 3'd7, 1, 0, 0, 0, 3'd0));
      runStep(mkVec("mid_reset1",  1, 1, 1, 3'd7, 0, 0, 0, 0, 3'd0));
      runStep(mkVec("post_idle",   0, 0, 1, 3'd2, 0, 0, 0, 0, 3'd0));
      runStep(mkVec("post_idle2",  0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0));
      runStep(mkVec("post_start",  0, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0));
      runStep(mkVec("post_w1",     0, 0, 1, 3'd1, 0, 1, 0, 0, 3'd1));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
